// File: rtl/alu_issue.sv
// alu_issue: decodes one MIPS-style instruction, drives the external alu, and returns
// writeback data, a branch decision or an exception. Optional MUL/DIV: ALU_ISSUE_MULDIV_EN.

package alu_issue_pkg;
  localparam logic [4:0] ALUOP_MOV = 5'd0;
  localparam logic [4:0] ALUOP_ADD = 5'd1;
  localparam logic [4:0] ALUOP_SUB = 5'd2;
  localparam logic [4:0] ALUOP_AND = 5'd3;
  localparam logic [4:0] ALUOP_OR  = 5'd4;
  localparam logic [4:0] ALUOP_XOR = 5'd5;
  localparam logic [4:0] ALUOP_NOR = 5'd6;
  localparam logic [4:0] ALUOP_SLT = 5'd7;
  localparam logic [4:0] ALUOP_SLL = 5'd8;
  localparam logic [4:0] ALUOP_SRL = 5'd9;
  localparam logic [4:0] ALUOP_SRA = 5'd10;
  localparam logic [4:0] ALUOP_LUI = 5'd11;
  localparam logic [4:0] ALUOP_BEQ = 5'd12;
  localparam logic [4:0] ALUOP_BNE = 5'd13;
  localparam logic [4:0] ALUOP_MUL = 5'd14;
  localparam logic [4:0] ALUOP_DIV = 5'd15;
endpackage

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int N         = 32,
  parameter int MD_SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] rs_val,
  input  logic [N-1:0] rt_val,
  output logic [4:0]   aluop,
  output logic [N-1:0] alu_s,
  output logic [N-1:0] alu_t,
  output logic [4:0]   alu_shamt,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [4:0]   res_wreg,
  output logic         res_we,
  output logic         br_taken,
  output logic [N-1:0] br_target,
  output logic         exc_ovf,
  output logic         exc_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_e;

  typedef struct packed {
    logic [4:0]   aluop;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic [4:0]   shamt;
    logic [4:0]   wreg;
    logic         we;
    logic         chk_ovf;
    logic         is_br;
    logic         illegal;
`ifdef ALU_ISSUE_MULDIV_EN
    logic         md;
    logic         div_zero;
`endif
  } dec_t;

  state_e state_q, state_d;
  dec_t   dec;
  logic   accept;
  logic   exec_last;
  logic   we_q, chk_ovf_q, is_br_q, div_zero_q;
  logic   ovf_now;

  logic [5:0]   op, funct;
  logic [4:0]   rt_f, rd_f;
  logic [15:0]  imm;
  logic [N-1:0] imm_sext, imm_zext;

  assign op       = instr[31:26];
  assign rt_f     = instr[20:16];
  assign rd_f     = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{(N-16){imm[15]}}, imm};
  assign imm_zext = {{(N-16){1'b0}}, imm};

  // The rs field is never needed: its value arrives already read as rs_val.
  logic unused_rs_field;
  assign unused_rs_field = &{1'b0, instr[25:21]};

  // NOTE: every field gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    dec         = '0;
    dec.aluop   = ALUOP_MOV;
    dec.s       = rs_val;
    dec.t       = rt_val;
    dec.wreg    = rt_f;
    unique case (op)
      6'h00: begin
        dec.wreg = rd_f;
        unique case (funct)
          6'h00, 6'h02, 6'h03: begin
            dec.aluop = (funct == 6'h00) ? ALUOP_SLL :
                        (funct == 6'h02) ? ALUOP_SRL : ALUOP_SRA;
            dec.s     = rt_val;
            dec.t     = '0;
            dec.shamt = instr[10:6];
          end
          6'h20: begin dec.aluop = ALUOP_ADD; dec.chk_ovf = 1'b1; end
          6'h21: dec.aluop = ALUOP_ADD;
          6'h22: begin dec.aluop = ALUOP_SUB; dec.chk_ovf = 1'b1; end
          6'h23: dec.aluop = ALUOP_SUB;
          6'h24: dec.aluop = ALUOP_AND;
          6'h25: dec.aluop = ALUOP_OR;
          6'h26: dec.aluop = ALUOP_XOR;
          6'h27: dec.aluop = ALUOP_NOR;
          6'h2A: dec.aluop = ALUOP_SLT;
`ifdef ALU_ISSUE_MULDIV_EN
          6'h18: begin dec.aluop = ALUOP_MUL; dec.chk_ovf = 1'b1; dec.md = 1'b1; end
          6'h1A: begin
            dec.aluop    = ALUOP_DIV;
            dec.chk_ovf  = 1'b1;
            dec.md       = 1'b1;
            dec.div_zero = (rt_val == '0);
          end
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h04: begin dec.aluop = ALUOP_BEQ; dec.is_br = 1'b1; end
      6'h05: begin dec.aluop = ALUOP_BNE; dec.is_br = 1'b1; end
      6'h08: begin dec.aluop = ALUOP_ADD; dec.t = imm_sext; dec.chk_ovf = 1'b1; end
      6'h09: begin dec.aluop = ALUOP_ADD; dec.t = imm_sext; end
      6'h0A: begin dec.aluop = ALUOP_SLT; dec.t = imm_sext; end
      6'h0C: begin dec.aluop = ALUOP_AND; dec.t = imm_zext; end
      6'h0D: begin dec.aluop = ALUOP_OR;  dec.t = imm_zext; end
      6'h0E: begin dec.aluop = ALUOP_XOR; dec.t = imm_zext; end
      6'h0F: begin dec.aluop = ALUOP_LUI; dec.t = imm_zext; end
      default: dec.illegal = 1'b1;
    endcase
    dec.we = !dec.is_br && !dec.illegal && (dec.wreg != 5'd0);
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

`ifdef ALU_ISSUE_MULDIV_EN
  localparam int CW = (MD_SETTLE > 1) ? $clog2(MD_SETTLE) : 1;
  logic [CW-1:0] cnt_q;

  // Loaded on accept so EXEC lasts MD_SETTLE cycles for MUL/DIV and one cycle otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= dec.md ? CW'(MD_SETTLE - 1) : '0;
    end else if (state_q == EXEC && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign exec_last = (cnt_q == '0);
`else
  assign exec_last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = dec.illegal ? DONE : EXEC;
      EXEC: if (exec_last) state_d = CAPT;
      CAPT: state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign ovf_now = (chk_ovf_q && alu_overflow) || div_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluop       <= ALUOP_MOV;
      alu_s       <= '0;
      alu_t       <= '0;
      alu_shamt   <= '0;
      res_data    <= '0;
      res_wreg    <= '0;
      res_we      <= 1'b0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      exc_ovf     <= 1'b0;
      exc_illegal <= 1'b0;
      we_q        <= 1'b0;
      chk_ovf_q   <= 1'b0;
      is_br_q     <= 1'b0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      aluop       <= dec.aluop;
      alu_s       <= dec.s;
      alu_t       <= dec.t;
      alu_shamt   <= dec.shamt;
      res_data    <= '0;
      res_wreg    <= dec.wreg;
      res_we      <= 1'b0;
      br_taken    <= 1'b0;
      br_target   <= dec.is_br ? (pc + N'(4) + {imm_sext[N-3:0], 2'b00}) : '0;
      exc_ovf     <= 1'b0;
      exc_illegal <= dec.illegal;
      we_q        <= dec.we;
      chk_ovf_q   <= dec.chk_ovf;
      is_br_q     <= dec.is_br;
`ifdef ALU_ISSUE_MULDIV_EN
      div_zero_q  <= dec.div_zero;
`else
      div_zero_q  <= 1'b0;
`endif
    end else if (state_q == CAPT) begin
      res_data <= alu_out;
      exc_ovf  <= ovf_now;
      res_we   <= we_q && !ovf_now;
      br_taken <= is_br_q && alu_zero;
    end
  end

endmodule
